// File: rtl/pacman_dir_ctrl.sv
// pacman_dir_ctrl: queues one key-driven turn and commits it once per frame
// as a 1-clk pulse on the mover's direction lines.
// Inputs : clk, resetN (async, low), startOfFrame, key_up/right/down/left,
//          collision, HitEdgeCode[2:0], topLeftX/Y[10:0] (signed).
// Outputs: Y_direction_key (down), toggle_x_key (right), Y_direction_key_up,
//          toggle_x_key_left, cur_dir[1:0] (0=U 1=R 2=D 3=L), turn_pending.
// Option : define DIR_CTRL_TIMEOUT_EN to drop a turn after QUEUE_TIMEOUT
//          frames without a commit.
module pacman_dir_ctrl #(
    parameter int TILE_SIZE     = 32,
    parameter int ALIGN_TOL     = 1,
    parameter int QUEUE_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               key_up,
    input  logic               key_right,
    input  logic               key_down,
    input  logic               key_left,
    input  logic               collision,
    input  logic        [2:0]  HitEdgeCode,
    input  logic signed [10:0] topLeftX,
    input  logic signed [10:0] topLeftY,
    output logic               Y_direction_key,
    output logic               toggle_x_key,
    output logic               Y_direction_key_up,
    output logic               toggle_x_key_left,
    output logic        [1:0]  cur_dir,
    output logic               turn_pending
);

    localparam int OFS_W = $clog2(TILE_SIZE);
    localparam logic [OFS_W-1:0] TOL = OFS_W'(ALIGN_TOL);

    localparam logic [1:0] WAIT_SOF = 2'd0;
    localparam logic [1:0] SETTLE   = 2'd1;
    localparam logic [1:0] EVAL     = 2'd2;
    localparam logic [1:0] ISSUE    = 2'd3;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [1:0] settle_q, settle_d;
    logic [3:0] key_q, key_d;
    logic [1:0] pend_dir_q, pend_dir_d;
    logic       turn_pending_q, turn_pending_d;
    logic [3:0] blocked_q, blocked_d;
    logic [1:0] cur_dir_q, cur_dir_d;
    logic [3:0] pulse_q, pulse_d;
`ifdef DIR_CTRL_TIMEOUT_EN
    localparam logic [3:0] TMO = 4'(QUEUE_TIMEOUT);
    logic [3:0] frame_cnt_q, frame_cnt_d;
`endif

    // Key vectors are indexed by direction code: [0]=U [1]=R [2]=D [3]=L.
    logic [3:0] keys;
    logic [3:0] rise;
    logic [1:0] new_dir;
    logic       aligned;
    logic       rev;
    logic       same;
    logic       commit;
    logic       unused_bits;

    assign keys = {key_left, key_down, key_right, key_up};
    assign rise = keys & ~key_q;

    // Negative coordinates never count as aligned.
    assign aligned = !topLeftX[10] && !topLeftY[10]
                  && (topLeftX[OFS_W-1:0] <= TOL)
                  && (topLeftY[OFS_W-1:0] <= TOL);

    assign rev    = (pend_dir_q == (cur_dir_q ^ 2'd2));
    assign same   = (pend_dir_q == cur_dir_q);
    assign commit = !same && (rev || (aligned && !blocked_q[pend_dir_q]));

    assign unused_bits = ^{topLeftX[9:OFS_W], topLeftY[9:OFS_W]};

    // Overlapping rises are expected, so the chain is priority-ordered.
    always_comb begin
        new_dir = DIR_RIGHT;
        priority case (1'b1)
            rise[0]: new_dir = DIR_UP;
            rise[2]: new_dir = DIR_DOWN;
            rise[3]: new_dir = DIR_LEFT;
            default: new_dir = DIR_RIGHT;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        settle_d       = settle_q;
        key_d          = keys;
        pend_dir_d     = pend_dir_q;
        turn_pending_d = turn_pending_q;
        blocked_d      = blocked_q;
        cur_dir_d      = cur_dir_q;
        pulse_d        = 4'b0000;
`ifdef DIR_CTRL_TIMEOUT_EN
        frame_cnt_d    = frame_cnt_q;
`endif

        if (state_q != EVAL && collision) begin
            case (HitEdgeCode)
                3'd3:    blocked_d[DIR_UP]    = 1'b1;
                3'd2:    blocked_d[DIR_RIGHT] = 1'b1;
                3'd0:    blocked_d[DIR_DOWN]  = 1'b1;
                3'd1:    blocked_d[DIR_LEFT]  = 1'b1;
                default: ;
            endcase
        end

        case (state_q)
            WAIT_SOF: begin
                if (startOfFrame) begin
                    state_d  = SETTLE;
                    settle_d = 2'd2;
                end
            end
            SETTLE: begin
                if (settle_q == 2'd0) begin
                    state_d = EVAL;
                end else begin
                    settle_d = settle_q - 2'd1;
                end
            end
            EVAL: begin
                // The decision is registered here so the pulse, cur_dir
                // and turn_pending all change together at the ISSUE clk.
                state_d   = ISSUE;
                blocked_d = 4'b0000;
                if (turn_pending_q) begin
                    if (commit) begin
                        pulse_d        = 4'b0001 << pend_dir_q;
                        cur_dir_d      = pend_dir_q;
                        turn_pending_d = 1'b0;
                    end else if (same) begin
                        turn_pending_d = 1'b0;
                    end else begin
`ifdef DIR_CTRL_TIMEOUT_EN
                        frame_cnt_d = frame_cnt_q + 4'd1;
                        if (frame_cnt_d == TMO) begin
                            turn_pending_d = 1'b0;
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = WAIT_SOF;
            end
        endcase

        // A press always wins, even in the EVAL clk: it belongs to the
        // next frame while this EVAL used the older pend_dir.
        if (|rise) begin
            pend_dir_d     = new_dir;
            turn_pending_d = 1'b1;
`ifdef DIR_CTRL_TIMEOUT_EN
            frame_cnt_d    = 4'd0;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= WAIT_SOF;
            settle_q       <= 2'd0;
            key_q          <= 4'b0000;
            pend_dir_q     <= DIR_UP;
            turn_pending_q <= 1'b0;
            blocked_q      <= 4'b0000;
            cur_dir_q      <= DIR_RIGHT;
            pulse_q        <= 4'b0000;
`ifdef DIR_CTRL_TIMEOUT_EN
            frame_cnt_q    <= 4'd0;
`endif
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            key_q          <= key_d;
            pend_dir_q     <= pend_dir_d;
            turn_pending_q <= turn_pending_d;
            blocked_q      <= blocked_d;
            cur_dir_q      <= cur_dir_d;
            pulse_q        <= pulse_d;
`ifdef DIR_CTRL_TIMEOUT_EN
            frame_cnt_q    <= frame_cnt_d;
`endif
        end
    end

    assign Y_direction_key_up = pulse_q[0];
    assign toggle_x_key       = pulse_q[1];
    assign Y_direction_key    = pulse_q[2];
    assign toggle_x_key_left  = pulse_q[3];
    assign cur_dir            = cur_dir_q;
    assign turn_pending       = turn_pending_q;

endmodule

// File: tb/tb_pacman_dir_ctrl.sv
// tb_pacman_dir_ctrl: scoreboard bench for pacman_dir_ctrl.
// Expected pulses are queued with their cycle and matched by a monitor.
module tb_pacman_dir_ctrl;

    localparam logic [3:0] K_UP    = 4'b0001;
    localparam logic [3:0] K_RIGHT = 4'b0010;
    localparam logic [3:0] K_DOWN  = 4'b0100;
    localparam logic [3:0] K_LEFT  = 4'b1000;
    localparam logic [3:0] K_NONE  = 4'b0000;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame;
    logic               key_up, key_right, key_down, key_left;
    logic               collision;
    logic        [2:0]  HitEdgeCode;
    logic signed [10:0] topLeftX, topLeftY;
    logic               Y_direction_key, toggle_x_key;
    logic               Y_direction_key_up, toggle_x_key_left;
    logic        [1:0]  cur_dir;
    logic               turn_pending;

    pacman_dir_ctrl dut (
        .clk                (clk),
        .resetN             (resetN),
        .startOfFrame       (startOfFrame),
        .key_up             (key_up),
        .key_right          (key_right),
        .key_down           (key_down),
        .key_left           (key_left),
        .collision          (collision),
        .HitEdgeCode        (HitEdgeCode),
        .topLeftX           (topLeftX),
        .topLeftY           (topLeftY),
        .Y_direction_key    (Y_direction_key),
        .toggle_x_key       (toggle_x_key),
        .Y_direction_key_up (Y_direction_key_up),
        .toggle_x_key_left  (toggle_x_key_left),
        .cur_dir            (cur_dir),
        .turn_pending       (turn_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic [3:0] pv;
        int         at;
    } exp_t;
    exp_t sbq[$];

    logic [3:0] pulses;
    assign pulses = {toggle_x_key_left, Y_direction_key,
                     toggle_x_key, Y_direction_key_up};

    // Every high pulse cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (pulses != 4'b0000) begin
            vecs++;
            if (sbq.size() == 0) begin
                errs++;
                $display("FAIL unexpected_pulse: got %b at cycle %0d, required none",
                         pulses, cyc);
            end else begin
                e = sbq.pop_front();
                if (pulses !== e.pv || cyc != e.at) begin
                    errs++;
                    $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                             pulses, cyc, e.pv, e.at);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        {key_left, key_down, key_right, key_up} = k;
        tick(1);
        {key_left, key_down, key_right, key_up} = 4'b0000;
        tick(1);
    endtask

    task automatic sof(output int c0);
        startOfFrame = 1'b1;
        c0 = cyc;
        tick(1);
        startOfFrame = 1'b0;
    endtask

    task automatic frame(input logic [3:0] expv);
        int c0;
        sof(c0);
        if (expv != 4'b0000) sbq.push_back('{expv, c0 + 5});
        tick(11);
    endtask

    task automatic do_reset;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        {key_left, key_down, key_right, key_up} = 4'b0000;
        collision    = 1'b0;
        HitEdgeCode  = 3'd0;
        tick(2);
        resetN = 1'b1;
        tick(2);
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        startOfFrame = 1'b0;
        {key_left, key_down, key_right, key_up} = 4'b0000;
        collision = 1'b0;
        HitEdgeCode = 3'd0;
        topLeftX = 11'sd0;
        topLeftY = 11'sd0;
        tick(2);
        vecs++;
        if (pulses !== 4'b0000) begin
            errs++;
            $display("FAIL rst_pulses: got %b, required 0000", pulses);
        end
        vecs++;
        if (cur_dir !== 2'd1) begin
            errs++;
            $display("FAIL rst_cur_dir: got %0d, required 1", cur_dir);
        end
        vecs++;
        if (turn_pending !== 1'b0) begin
            errs++;
            $display("FAIL rst_pending: got %b, required 0", turn_pending);
        end
        resetN = 1'b1;
        frame(K_NONE);
        vecs++;
        if (turn_pending !== 1'b0 || cur_dir !== 2'd1) begin
            errs++;
            $display("FAIL idle_frame: got pend=%b dir=%0d, required pend=0 dir=1",
                     turn_pending, cur_dir);
        end
    endtask

    task automatic test_turn_up;
        do_reset();
        topLeftX = 11'sd96;
        topLeftY = 11'sd64;
        press(K_UP);
        vecs++;
        if (turn_pending !== 1'b1) begin
            errs++;
            $display("FAIL t1_queued: got %b, required 1", turn_pending);
        end
        frame(K_UP);
        vecs++;
        if (cur_dir !== 2'd0 || turn_pending !== 1'b0) begin
            errs++;
            $display("FAIL t1_state: got dir=%0d pend=%b, required dir=0 pend=0",
                     cur_dir, turn_pending);
        end
        vecs++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL t1_missing: got %0d outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_misaligned;
        do_reset();
        topLeftX = -11'sd32;
        topLeftY = 11'sd64;
        press(K_DOWN);
        frame(K_NONE);
        vecs++;
        if (turn_pending !== 1'b1) begin
            errs++;
            $display("FAIL t2_neg_x: got pend=%b, required 1", turn_pending);
        end
        topLeftX = 11'sd98;
        frame(K_NONE);
        vecs++;
        if (turn_pending !== 1'b1 || cur_dir !== 2'd1) begin
            errs++;
            $display("FAIL t2_tol: got pend=%b dir=%0d, required pend=1 dir=1",
                     turn_pending, cur_dir);
        end
        topLeftX = 11'sd128;
        frame(K_DOWN);
        vecs++;
        if (cur_dir !== 2'd2 || turn_pending !== 1'b0) begin
            errs++;
            $display("FAIL t2_commit: got dir=%0d pend=%b, required dir=2 pend=0",
                     cur_dir, turn_pending);
        end
        vecs++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL t2_missing: got %0d outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reverse;
        do_reset();
        topLeftX = 11'sd101;
        topLeftY = 11'sd64;
        press(K_LEFT);
        frame(K_LEFT);
        vecs++;
        if (cur_dir !== 2'd3 || sbq.size() != 0) begin
            errs++;
            $display("FAIL t3_reverse: got dir=%0d outstanding=%0d, required dir=3 outstanding=0",
                     cur_dir, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_blocked;
        do_reset();
        topLeftX = 11'sd97;
        topLeftY = 11'sd65;
        press(K_UP);
        collision = 1'b1;
        HitEdgeCode = 3'd3;
        tick(1);
        collision = 1'b0;
        frame(K_NONE);
        vecs++;
        if (turn_pending !== 1'b1 || cur_dir !== 2'd1) begin
            errs++;
            $display("FAIL t4_blocked: got pend=%b dir=%0d, required pend=1 dir=1",
                     turn_pending, cur_dir);
        end
        frame(K_UP);
        vecs++;
        if (cur_dir !== 2'd0) begin
            errs++;
            $display("FAIL t4_unblocked: got dir=%0d, required 0", cur_dir);
        end
        // Codes 4..7 and hits on other sides must not block a left turn.
        press(K_LEFT);
        collision = 1'b1;
        HitEdgeCode = 3'd4;
        tick(1);
        HitEdgeCode = 3'd7;
        tick(1);
        HitEdgeCode = 3'd2;
        tick(1);
        collision = 1'b0;
        frame(K_LEFT);
        vecs++;
        if (cur_dir !== 2'd3 || sbq.size() != 0) begin
            errs++;
            $display("FAIL t4_ignored_codes: got dir=%0d outstanding=%0d, required dir=3 outstanding=0",
                     cur_dir, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_same_dir;
        press(K_LEFT);
        vecs++;
        if (turn_pending !== 1'b1) begin
            errs++;
            $display("FAIL same_queued: got %b, required 1", turn_pending);
        end
        frame(K_NONE);
        vecs++;
        if (turn_pending !== 1'b0 || cur_dir !== 2'd3) begin
            errs++;
            $display("FAIL same_drop: got pend=%b dir=%0d, required pend=0 dir=3",
                     turn_pending, cur_dir);
        end
    endtask

    task automatic test_eval_press;
        int c0;
        do_reset();
        topLeftX = 11'sd100;
        topLeftY = 11'sd64;
        press(K_DOWN);
        sof(c0);
        tick(3);
        key_left = 1'b1;
        tick(1);
        key_left = 1'b0;
        tick(7);
        vecs++;
        if (turn_pending !== 1'b1 || cur_dir !== 2'd1) begin
            errs++;
            $display("FAIL eval_press_defer: got pend=%b dir=%0d, required pend=1 dir=1",
                     turn_pending, cur_dir);
        end
        frame(K_LEFT);
        vecs++;
        if (cur_dir !== 2'd3 || sbq.size() != 0) begin
            errs++;
            $display("FAIL eval_press_next: got dir=%0d outstanding=%0d, required dir=3 outstanding=0",
                     cur_dir, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        do_reset();
        topLeftX = 11'sd96;
        topLeftY = 11'sd64;
        press(K_UP);
        sof(c0);
        sbq.push_back('{K_UP, c0 + 5});
        tick(1);
        startOfFrame = 1'b1;
        tick(1);
        startOfFrame = 1'b0;
        tick(10);
        press(K_RIGHT);
        frame(K_RIGHT);
        vecs++;
        if (cur_dir !== 2'd1 || sbq.size() != 0) begin
            errs++;
            $display("FAIL b2b: got dir=%0d outstanding=%0d, required dir=1 outstanding=0",
                     cur_dir, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_prio_reset;
        int c0;
        do_reset();
        topLeftX = 11'sd96;
        topLeftY = 11'sd64;
        press(K_UP | K_LEFT);
        frame(K_UP);
        press(K_DOWN | K_RIGHT);
        frame(K_DOWN);
        press(K_LEFT | K_RIGHT);
        frame(K_LEFT);
        vecs++;
        if (cur_dir !== 2'd3 || sbq.size() != 0) begin
            errs++;
            $display("FAIL prio: got dir=%0d outstanding=%0d, required dir=3 outstanding=0",
                     cur_dir, sbq.size());
            sbq.delete();
        end
        press(K_UP);
        sof(c0);
        tick(1);
        resetN = 1'b0;
        #1;
        vecs++;
        if (pulses !== 4'b0000 || turn_pending !== 1'b0 || cur_dir !== 2'd1) begin
            errs++;
            $display("FAIL midframe_reset: got p=%b pend=%b dir=%0d, required p=0000 pend=0 dir=1",
                     pulses, turn_pending, cur_dir);
        end
        tick(1);
        resetN = 1'b1;
        tick(12);
        frame(K_NONE);
        vecs++;
        if (turn_pending !== 1'b0 || cur_dir !== 2'd1) begin
            errs++;
            $display("FAIL post_reset: got pend=%b dir=%0d, required pend=0 dir=1",
                     turn_pending, cur_dir);
        end
    endtask

    task automatic test_timeout;
        logic exp_last;
        do_reset();
        topLeftX = 11'sd100;
        topLeftY = 11'sd64;
        press(K_DOWN);
        for (int i = 0; i < 14; i++) frame(K_NONE);
        vecs++;
        if (turn_pending !== 1'b1) begin
            errs++;
            $display("FAIL timeout_14: got %b, required 1", turn_pending);
        end
`ifdef DIR_CTRL_TIMEOUT_EN
        exp_last = 1'b0;
`else
        exp_last = 1'b1;
`endif
        frame(K_NONE);
        vecs++;
        if (turn_pending !== exp_last) begin
            errs++;
            $display("FAIL timeout_15: got %b, required %b", turn_pending, exp_last);
        end
        frame(K_NONE);
        vecs++;
        if (turn_pending !== exp_last || cur_dir !== 2'd1) begin
            errs++;
            $display("FAIL timeout_16: got pend=%b dir=%0d, required pend=%b dir=1",
                     turn_pending, cur_dir, exp_last);
        end
    endtask

    initial begin
        test_reset();
        test_turn_up();
        test_misaligned();
        test_reverse();
        test_blocked();
        test_same_dir();
        test_eval_press();
        test_back_to_back();
        test_prio_reset();
        test_timeout();
        tick(4);
        vecs++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL final_missing: got %0d outstanding, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
